// File: rtl/pc_seq_ctrl_pkg.sv
// Shared definitions for the Y86-64 multi-cycle sequencer: instruction codes,
// machine status encodings, controller state encodings and default widths.
package pc_seq_ctrl_pkg;

  localparam int DATA_WID = 64;

  // Y86-64 instruction codes
  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOV  = 4'h2;  // also CMOVXX
  localparam logic [3:0] I_IRMOV  = 4'h3;
  localparam logic [3:0] I_RMMOV  = 4'h4;
  localparam logic [3:0] I_MRMOV  = 4'h5;
  localparam logic [3:0] I_OP     = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSH   = 4'hA;
  localparam logic [3:0] I_POP    = 4'hB;

  typedef enum logic [1:0] {
    STAT_AOK = 2'd0,
    STAT_HLT = 2'd1,
    STAT_ADR = 2'd2,
    STAT_INS = 2'd3
  } stat_e;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEMORY    = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_PCUPDATE  = 3'd5,
    ST_STOP      = 3'd6
  } state_e;

  // Instructions that need a data memory access after EXECUTE
  function automatic logic is_mem_class(input logic [3:0] ic);
    return (ic == I_RMMOV) || (ic == I_MRMOV) || (ic == I_CALL) ||
           (ic == I_RET)   || (ic == I_PUSH)  || (ic == I_POP);
  endfunction

endpackage

// File: rtl/pc_seq_ctrl_pc_next_calc.sv
// Combinational next-PC selection: CALL and taken JXX go to valC, RET goes to
// valM, everything else advances by the instruction length (modulo 2^DATA_WID).
module pc_next_calc
  import pc_seq_ctrl_pkg::*;
#(
  parameter int DATA_WID = 64
) (
  input  logic [DATA_WID-1:0] pc,
  input  logic [3:0]          icode,
  input  logic                cnd,
  input  logic [DATA_WID-1:0] valc,
  input  logic [DATA_WID-1:0] valm,
  output logic [DATA_WID-1:0] next_pc
);

  logic [3:0] len;

  // Instruction length table and target selection
  always_comb begin
    len = 4'd1;
    case (icode)
      I_NOP, I_RET:                      len = 4'd1;
      I_RRMOV, I_OP, I_PUSH, I_POP:      len = 4'd2;
      I_JXX, I_CALL:                     len = 4'd9;
      I_IRMOV, I_RMMOV, I_MRMOV:         len = 4'd10;
      default:                           len = 4'd1;
    endcase

    next_pc = pc + {{(DATA_WID-4){1'b0}}, len};
    if (icode == I_CALL) begin
      next_pc = valc;
    end else if ((icode == I_JXX) && cnd) begin
      next_pc = valc;
    end else if (icode == I_RET) begin
      next_pc = valm;
    end
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Multi-cycle Y86-64 sequencer. Owns the PC, walks each instruction through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/PCUPDATE and reports machine status.
// Optional single-step gating of FETCH is enabled with macro PC_SEQ_STEP_EN.
//
// Handshake: a request (imem_req/dmem_req) is registered; it rises in the first
// cycle of FETCH/MEMORY and stays high through the cycle in which the matching
// ack is seen. An ack is only accepted while its request is high and never in a
// cycle where rst is high.
module pc_seq_ctrl #(
  parameter int                  DATA_WID = pc_seq_ctrl_pkg::DATA_WID,
  parameter logic [DATA_WID-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
`ifdef PC_SEQ_STEP_EN
  input  logic                step,
`endif
  output logic                imem_req,
  input  logic                imem_ack,
  input  logic                imem_err,
  input  logic [3:0]          icode,
  input  logic [DATA_WID-1:0] valC,
  input  logic                cnd,
  output logic                dmem_req,
  input  logic                dmem_ack,
  input  logic                dmem_err,
  input  logic [DATA_WID-1:0] valM,
  output logic                dec_en,
  output logic                exe_en,
  output logic                wb_en,
  output logic [DATA_WID-1:0] pc,
  output logic [1:0]          stat
);

  import pc_seq_ctrl_pkg::*;

  state_e              state_q, state_d;
  stat_e               stat_q, stat_d;
  logic [DATA_WID-1:0] pc_q, pc_d;
  logic [3:0]          icode_q, icode_d;
  logic [DATA_WID-1:0] valc_q, valc_d;
  logic [DATA_WID-1:0] valm_q, valm_d;
  logic                cnd_q, cnd_d;
  logic                imem_req_q, imem_req_d;
  logic                dmem_req_q, dmem_req_d;
  logic                fetch_ok;
  logic [DATA_WID-1:0] next_pc;

  pc_next_calc #(
    .DATA_WID (DATA_WID)
  ) u_pc_next_calc (
    .pc      (pc_q),
    .icode   (icode_q),
    .cnd     (cnd_q),
    .valc    (valc_q),
    .valm    (valm_q),
    .next_pc (next_pc)
  );

`ifdef PC_SEQ_STEP_EN
  // Once a fetch request is up it stays up until acked; a new one needs step
  assign fetch_ok = imem_req_q || step;
`else
  assign fetch_ok = 1'b1;
`endif

  // Next-state, datapath latches, stage enables and registered request inputs
  always_comb begin
    state_d    = state_q;
    stat_d     = stat_q;
    pc_d       = pc_q;
    icode_d    = icode_q;
    valc_d     = valc_q;
    valm_d     = valm_q;
    cnd_d      = cnd_q;
    dec_en     = 1'b0;
    exe_en     = 1'b0;
    wb_en      = 1'b0;

    case (state_q)
      ST_FETCH: begin
        if (imem_req_q && imem_ack) begin
          icode_d = icode;
          valc_d  = valC;
          if (imem_err) begin
            stat_d  = STAT_ADR;
            state_d = ST_STOP;
          end else if (icode > I_POP) begin
            stat_d  = STAT_INS;
            state_d = ST_STOP;
          end else if (icode == I_HALT) begin
            stat_d  = STAT_HLT;
            state_d = ST_STOP;
          end else begin
            state_d = ST_DECODE;
          end
        end
      end
      ST_DECODE: begin
        dec_en  = 1'b1;
        state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        exe_en  = 1'b1;
        cnd_d   = cnd;
        state_d = is_mem_class(icode_q) ? ST_MEMORY : ST_WRITEBACK;
      end
      ST_MEMORY: begin
        if (dmem_req_q && dmem_ack) begin
          valm_d = valM;
          if (dmem_err) begin
            stat_d  = STAT_ADR;
            state_d = ST_STOP;
          end else begin
            state_d = ST_WRITEBACK;
          end
        end
      end
      ST_WRITEBACK: begin
        wb_en   = 1'b1;
        state_d = ST_PCUPDATE;
      end
      ST_PCUPDATE: begin
        pc_d    = next_pc;
        state_d = ST_FETCH;
      end
      ST_STOP: begin
        state_d = ST_STOP;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase

    // Requests are registered off the next state so they appear on state entry
    imem_req_d = (state_d == ST_FETCH) && fetch_ok;
    dmem_req_d = (state_d == ST_MEMORY);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      stat_q     <= STAT_AOK;
      pc_q       <= RESET_PC;
      icode_q    <= I_NOP;
      valc_q     <= '0;
      valm_q     <= '0;
      cnd_q      <= 1'b0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      stat_q     <= stat_d;
      pc_q       <= pc_d;
      icode_q    <= icode_d;
      valc_q     <= valc_d;
      valm_q     <= valm_d;
      cnd_q      <= cnd_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
    end
  end

  assign imem_req = imem_req_q;
  assign dmem_req = dmem_req_q;
  assign pc       = pc_q;
  assign stat     = stat_q;

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl. Drivers answer the memory handshakes;
// every expected {stat, pc} change is queued and a negedge monitor compares
// each observed change against the queue head.
`timescale 1ns/1ps
module tb_pc_seq_ctrl;
  import pc_seq_ctrl_pkg::*;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         imem_req, imem_ack, imem_err;
  logic [3:0]   icode;
  logic [W-1:0] valC;
  logic         cnd;
  logic         dmem_req, dmem_ack, dmem_err;
  logic [W-1:0] valM;
  logic         dec_en, exe_en, wb_en;
  logic [W-1:0] pc;
  logic [1:0]   stat;
`ifdef PC_SEQ_STEP_EN
  logic         step = 1'b1;
`endif

  pc_seq_ctrl #(.DATA_WID(W), .RESET_PC('0)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef PC_SEQ_STEP_EN
    .step     (step),
`endif
    .imem_req (imem_req),
    .imem_ack (imem_ack),
    .imem_err (imem_err),
    .icode    (icode),
    .valC     (valC),
    .cnd      (cnd),
    .dmem_req (dmem_req),
    .dmem_ack (dmem_ack),
    .dmem_err (dmem_err),
    .valM     (valM),
    .dec_en   (dec_en),
    .exe_en   (exe_en),
    .wb_en    (wb_en),
    .pc       (pc),
    .stat     (stat)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [W+1:0] exp_q[$];
  logic [W+1:0] last_obs;
  logic         mon_en = 1'b0;
  int           n_tests = 0;
  int           n_fail  = 0;
  int           imem_hi = 0;
  int           dmem_hi = 0;
  int           wb_cnt  = 0;

  task automatic check(input string name, input logic [W+1:0] got, input logic [W+1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: count handshake activity and compare every {stat,pc} change
  always @(negedge clk) begin
    if (imem_req === 1'b1) imem_hi++;
    if (dmem_req === 1'b1) dmem_hi++;
    if (wb_en === 1'b1)    wb_cnt++;
    if (mon_en && ({stat, pc} !== last_obs)) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_change: got %0h expected none", {stat, pc});
      end else begin
        check("retire", {stat, pc}, exp_q.pop_front());
      end
      last_obs = {stat, pc};
    end
  end

  // ---------------- drivers ----------------
  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic do_fetch(input logic [3:0] ic, input logic [W-1:0] vc, input logic err,
                          input int dly, input logic c, output int seen);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (imem_req !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL imem_timeout: got no request expected request");
      seen = -1;
      return;
    end
    seen = cyc;
    cnd  = c;
    repeat (dly) begin
      @(posedge clk); #1;
    end
    imem_ack = 1'b1;
    imem_err = err;
    icode    = ic;
    valC     = vc;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    imem_err = 1'b0;
  endtask

  task automatic do_mem(input logic [W-1:0] vm, input logic err, input int dly);
    int n;
    n = 0;
    while (dmem_req !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (dmem_req !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL dmem_timeout: got no request expected request");
      return;
    end
    repeat (dly) begin
      @(posedge clk); #1;
    end
    dmem_ack = 1'b1;
    dmem_err = err;
    valM     = vm;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    dmem_err = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t0, t1, h, d, w, n;
    logic [W-1:0] ones;
    ones = '1;
    rst = 1'b1; imem_ack = 1'b0; imem_err = 1'b0; icode = 4'h0; valC = '0;
    cnd = 1'b0; dmem_ack = 1'b0; dmem_err = 1'b0; valM = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pc", pc, 0);
    check("rst_stat", stat, 0);
    check("rst_imem_req", imem_req, 0);
    check("rst_dmem_req", dmem_req, 0);
    check("rst_enables", {dec_en, exe_en, wb_en}, 0);
    rst = 1'b0;
    last_obs = {stat, pc};
    mon_en = 1'b1;

    // NOP, NOP, HALT from 0 with zero-wait fetch
    exp_q.push_back({2'd0, 64'd1});
    do_fetch(I_NOP, '0, 1'b0, 0, 1'b0, t0);
    exp_q.push_back({2'd0, 64'd2});
    do_fetch(I_NOP, '0, 1'b0, 0, 1'b0, t1);
    check("nop_latency", t1 - t0, 5);
    exp_q.push_back({2'd1, 64'd2});
    t0 = t1;
    do_fetch(I_HALT, '0, 1'b0, 0, 1'b0, t1);
    check("nop2_latency", t1 - t0, 5);
    repeat (10) @(posedge clk);
    #1;
    check("halt_frozen", {stat, pc}, {2'd1, 64'd2});
    check("stop_imem_req", imem_req, 0);
    exp_q.push_back({2'd0, 64'd0});
    do_reset();

    // Jump to 0x10, then IRMOV with a 3-cycle request
    exp_q.push_back({2'd0, 64'h10});
    do_fetch(I_JXX, 64'h10, 1'b0, 0, 1'b1, t0);
    h = imem_hi;
    d = dmem_hi;
    exp_q.push_back({2'd0, 64'h1A});
    do_fetch(I_IRMOV, 64'hdead, 1'b0, 2, 1'b0, t0);
    check("irmov_req_cycles", imem_hi - h, 3);

    // JXX not taken then taken
    exp_q.push_back({2'd0, 64'h23});
    do_fetch(I_JXX, 64'h100, 1'b0, 0, 1'b0, t0);
    check("irmov_no_dmem", dmem_hi - d, 0);
    exp_q.push_back({2'd0, 64'h100});
    do_fetch(I_JXX, 64'h100, 1'b0, 0, 1'b1, t0);

    // CALL then RET
    d = dmem_hi;
    exp_q.push_back({2'd0, 64'h200});
    do_fetch(I_CALL, 64'h200, 1'b0, 0, 1'b0, t0);
    do_mem(64'h0, 1'b0, 0);
    check("call_dmem_once", dmem_hi - d, 1);
    exp_q.push_back({2'd0, 64'h55});
    do_fetch(I_RET, 64'h0, 1'b0, 0, 1'b0, t1);
    check("mem_latency", t1 - t0, 6);
    do_mem(64'h55, 1'b0, 0);
    check("ret_dmem_once", dmem_hi - d, 2);

    // Illegal instruction
    exp_q.push_back({2'd3, 64'h55});
    do_fetch(4'hC, '0, 1'b0, 0, 1'b0, t0);
    repeat (5) @(posedge clk);
    #1;
    check("ins_stop_req", imem_req, 0);
    exp_q.push_back({2'd0, 64'd0});
    do_reset();

    // MRMOV with data address error: no writeback
    w = wb_cnt;
    exp_q.push_back({2'd2, 64'd0});
    do_fetch(I_MRMOV, 64'h8, 1'b0, 0, 1'b0, t0);
    do_mem(64'h0, 1'b1, 1);
    repeat (5) @(posedge clk);
    #1;
    check("adr_no_wb", wb_cnt - w, 0);
    exp_q.push_back({2'd0, 64'd0});
    do_reset();

    // PC wrap from all-ones
    exp_q.push_back({2'd0, ones});
    do_fetch(I_JXX, ones, 1'b0, 0, 1'b1, t0);
    exp_q.push_back({2'd0, 64'd0});
    do_fetch(I_NOP, '0, 1'b0, 0, 1'b0, t0);

    // Reset while waiting in MEMORY, ack coincident with reset
    do_fetch(I_MRMOV, 64'h30, 1'b0, 0, 1'b0, t0);
    n = 0;
    while (dmem_req !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("mem_wait_req", dmem_req, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    dmem_ack = 1'b1;
    valM = 64'h77;
    @(posedge clk); #1;
    check("rst_mid_dmem_req", dmem_req, 0);
    check("rst_mid_imem_req", imem_req, 0);
    check("rst_mid_state", {stat, pc}, {2'd0, 64'd0});
    dmem_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Ack without request is ignored
    imem_ack = 1'b1;
    icode = I_HALT;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    check("stray_ack_req", imem_req, 1);
    check("stray_ack_stat", stat, 0);
    exp_q.push_back({2'd0, 64'd1});
    do_fetch(I_NOP, '0, 1'b0, 0, 1'b0, t0);

    // Instruction fetch address error
    exp_q.push_back({2'd2, 64'd1});
    do_fetch(I_NOP, '0, 1'b1, 0, 1'b0, t0);
    repeat (6) @(posedge clk);
    #1;
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
